// File: rtl/logic_unit_pipe_if.sv
// Operand/result handshake bundle for logic_unit_pipe.
// The optional zero flag travels on the bus only when LU_ZERO_FLAG_EN is defined.
interface logic_unit_pipe_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       op;
    logic             chain;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] y;
    logic             chain_err;
`ifdef LU_ZERO_FLAG_EN
    logic             zero;
`endif

    modport master (
        output in_valid, a, b, op, chain, out_ready,
`ifdef LU_ZERO_FLAG_EN
        input  zero,
`endif
        input  in_ready, out_valid, y, chain_err
    );

    modport slave (
        input  in_valid, a, b, op, chain, out_ready,
`ifdef LU_ZERO_FLAG_EN
        output zero,
`endif
        output in_ready, out_valid, y, chain_err
    );
endinterface

// File: rtl/logic_unit_pipe.sv
// WIDTH-bit 8-op bitwise logic unit with chained accumulator operand and a 2-entry output FIFO.
// Define LU_ZERO_FLAG_EN to add a per-entry zero flag that follows y through the FIFO.
module logic_unit_pipe #(
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              reset,
    logic_unit_pipe_if.slave  bus
);
    typedef enum logic {ST_EMPTY, ST_ACC} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] acc_q;
    logic             chain_err_q;
    logic [1:0]       count_q, count_d;
    logic [WIDTH-1:0] slot_q [2];
    logic [WIDTH-1:0] slot_d [2];
`ifdef LU_ZERO_FLAG_EN
    logic             zflag_q [2];
    logic             zflag_d [2];
`endif

    logic             accept, deliver;
    logic [WIDTH-1:0] a_eff, r;

    // Ready depends only on stored occupancy (and reset), never on in_valid.
    assign bus.in_ready  = (count_q != 2'd2) && !reset;
    assign bus.out_valid = (count_q != 2'd0);
    assign bus.y         = slot_q[0];
    assign bus.chain_err = chain_err_q;
`ifdef LU_ZERO_FLAG_EN
    assign bus.zero      = zflag_q[0];
`endif

    assign accept = bus.in_valid && bus.in_ready;
    assign deliver = bus.out_valid && bus.out_ready;
    assign a_eff  = (bus.chain && state_q == ST_ACC) ? acc_q : bus.a;

    always_comb begin
        r = '0;
        case (bus.op)
            3'd0: r = ~(a_eff & bus.b);
            3'd1: r = a_eff & bus.b;
            3'd2: r = a_eff | bus.b;
            3'd3: r = ~(a_eff | bus.b);
            3'd4: r = a_eff ^ bus.b;
            3'd5: r = ~(a_eff ^ bus.b);
            3'd6: r = ~a_eff;
            default: r = bus.b;
        endcase
    end

    // Slot 0 is the head; it is left untouched when the last entry leaves so y holds.
    always_comb begin
        count_d = count_q;
        for (int i = 0; i < 2; i++) begin
            slot_d[i] = slot_q[i];
`ifdef LU_ZERO_FLAG_EN
            zflag_d[i] = zflag_q[i];
`endif
        end
        case ({accept, deliver})
            2'b10: begin
                slot_d[count_q[0]] = r;
`ifdef LU_ZERO_FLAG_EN
                zflag_d[count_q[0]] = (r == '0);
`endif
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                if (count_q == 2'd2) begin
                    slot_d[0] = slot_q[1];
`ifdef LU_ZERO_FLAG_EN
                    zflag_d[0] = zflag_q[1];
`endif
                end
                count_d = count_q - 2'd1;
            end
            2'b11: begin
                // Only reachable with one entry held: the new result replaces the head.
                slot_d[0] = r;
`ifdef LU_ZERO_FLAG_EN
                zflag_d[0] = (r == '0);
`endif
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                slot_q[i] <= '0;
`ifdef LU_ZERO_FLAG_EN
                zflag_q[i] <= 1'b0;
`endif
            end
        end else begin
            count_q <= count_d;
            for (int i = 0; i < 2; i++) begin
                slot_q[i] <= slot_d[i];
`ifdef LU_ZERO_FLAG_EN
                zflag_q[i] <= zflag_d[i];
`endif
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_EMPTY;
            acc_q       <= '0;
            chain_err_q <= 1'b0;
        end else if (accept) begin
            acc_q   <= r;
            state_q <= ST_ACC;
            if (bus.chain && state_q == ST_EMPTY) begin
                chain_err_q <= 1'b1;
            end
        end
    end
endmodule
